// File: rtl/mode_button_conditioner.sv
// Synchronizes and debounces the up/down/middle push buttons into clean levels and press pulses.
// Optional auto-repeat of up/down pulses while held is enabled by defining AUTOREPEAT_EN.
module mode_button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 20000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic btn_mid_raw,
   output logic up_lvl,
   output logic down_lvl,
   output logic mid_lvl,
   output logic up_pulse,
   output logic down_pulse,
   output logic mid_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("mode_button_conditioner: illegal parameter value");
   end

   typedef enum logic [1:0] {
      StReleased,
      StPressQual,
      StPressed,
      StReleaseQual
   } state_e;

   // Channel index: 0 = up, 1 = down, 2 = middle.
   logic [2:0]    raw;
   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    lvl_q, lvl_d;
   logic [2:0]    pulse_q, pulse_d;
   logic [2:0]    rise;
   logic [2:0]    press;
   logic [1:0]    rep_pulse;
   state_e        state_q [3];
   state_e        state_d [3];
   logic [CntW-1:0] cnt_q [3];
   logic [CntW-1:0] cnt_d [3];

   assign raw = {btn_mid_raw, btn_down_raw, btn_up_raw};

   always_comb begin
      lvl_d = lvl_q;
      rise  = '0;
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StReleased: begin
               if (sync2_q[i]) begin
                  state_d[i] = StPressQual;
                  cnt_d[i]   = CntW'(1);
               end
            end
            StPressQual: begin
               if (!sync2_q[i]) begin
                  state_d[i] = StReleased;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i] = StPressed;
                  lvl_d[i]   = 1'b1;
                  rise[i]    = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
            StPressed: begin
               if (!sync2_q[i]) begin
                  state_d[i] = StReleaseQual;
                  cnt_d[i]   = CntW'(1);
               end
            end
            StReleaseQual: begin
               if (sync2_q[i]) begin
                  state_d[i] = StPressed;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i] = StReleased;
                  lvl_d[i]   = 1'b0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
            default: begin
               state_d[i] = StReleased;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // A press is dropped if the opposite button is already held or qualifies in the same cycle.
   always_comb begin
      press[0] = rise[0] & ~lvl_q[1] & ~rise[1];
      press[1] = rise[1] & ~lvl_q[0] & ~rise[0];
      press[2] = rise[2];
      pulse_d  = press | {1'b0, rep_pulse};
   end

`ifdef AUTOREPEAT_EN
   localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HoldW   = $clog2(HoldMax + 1);

   logic [HoldW-1:0] hold_cnt_q [2];
   logic [HoldW-1:0] hold_cnt_d [2];
   logic [1:0]       hold_act_q, hold_act_d;
   logic [1:0]       hold_rep_q, hold_rep_d;

   always_comb begin
      rep_pulse = '0;
      for (int i = 0; i < 2; i++) begin
         hold_cnt_d[i] = hold_cnt_q[i];
         hold_act_d[i] = hold_act_q[i];
         hold_rep_d[i] = hold_rep_q[i];
         if (press[i]) begin
            hold_act_d[i] = 1'b1;
            hold_rep_d[i] = 1'b0;
            hold_cnt_d[i] = HoldW'(1);
         end else if (hold_act_q[i] && lvl_q[i] && !lvl_q[1-i]) begin
            // First terminal count is the initial delay, later ones the repeat period.
            if (hold_cnt_q[i] == (hold_rep_q[i] ? HoldW'(REPEAT_PERIOD) : HoldW'(REPEAT_DELAY)))
            begin
               rep_pulse[i]  = 1'b1;
               hold_rep_d[i] = 1'b1;
               hold_cnt_d[i] = HoldW'(1);
            end else begin
               hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
            end
         end else begin
            hold_act_d[i] = 1'b0;
            hold_rep_d[i] = 1'b0;
            hold_cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_act_q <= '0;
         hold_rep_q <= '0;
         for (int i = 0; i < 2; i++) begin
            hold_cnt_q[i] <= '0;
         end
      end else begin
         hold_act_q <= hold_act_d;
         hold_rep_q <= hold_rep_d;
         for (int i = 0; i < 2; i++) begin
            hold_cnt_q[i] <= hold_cnt_d[i];
         end
      end
   end
`else
   assign rep_pulse = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         pulse_q <= '0;
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= StReleased;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         pulse_q <= pulse_d;
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign up_lvl     = lvl_q[0];
   assign down_lvl   = lvl_q[1];
   assign mid_lvl    = lvl_q[2];
   assign up_pulse   = pulse_q[0];
   assign down_pulse = pulse_q[1];
   assign mid_pulse  = pulse_q[2];

endmodule

// File: tb/tb_mode_button_conditioner.sv
// Randomized and directed bench for mode_button_conditioner; a window-based reference model
// feeds an expectation queue that a negedge monitor drains against the DUT outputs.
module tb_mode_button_conditioner;

   localparam int unsigned DC = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_up_raw = 1'b0;
   logic btn_down_raw = 1'b0;
   logic btn_mid_raw = 1'b0;
   logic up_lvl, down_lvl, mid_lvl, up_pulse, down_pulse, mid_pulse;

   mode_button_conditioner #(
      .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_up_raw  (btn_up_raw),
      .btn_down_raw(btn_down_raw),
      .btn_mid_raw (btn_mid_raw),
      .up_lvl      (up_lvl),
      .down_lvl    (down_lvl),
      .mid_lvl     (mid_lvl),
      .up_pulse    (up_pulse),
      .down_pulse  (down_pulse),
      .mid_pulse   (mid_pulse)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [5:0]  exp_q[$];

   // Reference model: raw sample history per button; level follows the last DC synchronized
   // samples once they all agree; synchronized sample = raw sampled two edges earlier.
   logic [DC+1:0] m_hist [3];
   logic [2:0]    m_lvl;
   logic [2:0]    m_pulse;
   int            m_age [2];
   bit            m_act [2];

   function automatic void model_reset();
      for (int c = 0; c < 3; c++) m_hist[c] = '0;
      m_lvl   = '0;
      m_pulse = '0;
      for (int c = 0; c < 2; c++) begin
         m_age[c] = 0;
         m_act[c] = 1'b0;
      end
   endfunction

   function automatic void model_step(input logic [2:0] raw);
      logic [2:0]    prev;
      logic [2:0]    rise;
      logic [2:0]    press;
      logic [2:0]    rep;
      logic [DC-1:0] win;
      prev = m_lvl;
      for (int c = 0; c < 3; c++) begin
         m_hist[c] = {m_hist[c][DC:0], raw[c]};
         win = m_hist[c][DC+1:2];
         if (&win) m_lvl[c] = 1'b1;
         else if (~|win) m_lvl[c] = 1'b0;
      end
      rise     = m_lvl & ~prev;
      press[0] = rise[0] && !prev[1] && !rise[1];
      press[1] = rise[1] && !prev[0] && !rise[0];
      press[2] = rise[2];
      rep      = '0;
`ifdef AUTOREPEAT_EN
      for (int c = 0; c < 2; c++) begin
         if (press[c]) begin
            m_act[c] = 1'b1;
            m_age[c] = 0;
         end else if (m_act[c] && prev[c] && !prev[1-c]) begin
            m_age[c]++;
            if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) rep[c] = 1'b1;
         end else begin
            m_act[c] = 1'b0;
         end
      end
`endif
      m_pulse = press | rep;
   endfunction

   // One clock: advance the model for this edge, then apply the next inputs.
   task automatic tick(input logic [2:0] nxt_raw, input logic nxt_rst);
      @(posedge clk);
      if (rst_n) model_step({btn_mid_raw, btn_down_raw, btn_up_raw});
      else model_reset();
      if (!nxt_rst) model_reset();
      exp_q.push_back({m_pulse, m_lvl});
      #1;
      {btn_mid_raw, btn_down_raw, btn_up_raw} = nxt_raw;
      rst_n = nxt_rst;
   endtask

   task automatic hold(input logic [2:0] v, input int n);
      for (int k = 0; k < n; k++) tick(v, 1'b1);
   endtask

   always @(negedge clk) begin
      logic [5:0] e;
      logic [5:0] got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {mid_pulse, down_pulse, up_pulse, mid_lvl, down_lvl, up_lvl};
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t {mp,dp,up,ml,dl,ul} got=%b expected=%b", $time, got, e);
         end
      end
   end

   initial begin
      int          seg [3];
      logic [2:0]  r;
      logic        rs;
      model_reset();
      for (int k = 0; k < 3; k++) tick(3'b000, 1'b0);
      tick(3'b000, 1'b1);

      // Clean up press and release.
      hold(3'b001, 20);
      hold(3'b000, 12);
      // Bouncing down press.
      hold(3'b010, 1); hold(3'b000, 1); hold(3'b010, 1); hold(3'b000, 1);
      hold(3'b010, 12);
      hold(3'b000, 12);
      // Short middle glitch, then exactly DC-1 stable samples.
      hold(3'b100, 3);
      hold(3'b000, 10);
      // Exclusion: up first then down; then both together.
      hold(3'b001, 10);
      hold(3'b011, 15);
      hold(3'b000, 12);
      hold(3'b011, 15);
      hold(3'b000, 12);
      // Reset while up is held, then requalification.
      hold(3'b001, 10);
      tick(3'b001, 1'b0);
      tick(3'b001, 1'b0);
      tick(3'b001, 1'b1);
      hold(3'b001, 12);
      hold(3'b000, 12);
      // Long hold for auto-repeat.
      hold(3'b001, 35);
      hold(3'b000, 12);
      hold(3'b110, 35);
      hold(3'b000, 12);

      // Random bouncing on all three buttons with occasional resets.
      r = 3'b000;
      for (int c = 0; c < 3; c++) seg[c] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < 3; c++) begin
            if (seg[c] == 0) begin
               r[c]   = $urandom_range(0, 1) == 1;
               seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            end
            seg[c]--;
         end
         rs = ($urandom_range(0, 299) != 0);
         tick(r, rs);
      end
      hold(3'b000, 12);

      repeat (2) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
